ex_redirect_unit: RTL and testbench

Execute-stage control-hazard source for the instruction fetch path. It resolves branches and jumps in EX, computes the target, and issues a one-cycle registered `do_jump`/`jump_addr` redirect toward IF. It then squashes wrong-path instructions with a counted flush window and generates the pipeline `stall` for load-use and multiply/divide hazards. It is the producer side of the IF redirect/stall interface.

---
 rtl/ex_redirect_unit_pkg.sv | 34 +++
 rtl/ex_redirect_unit_if.sv | 44 ++++
 rtl/ex_redirect_unit_branch_resolve.sv | 55 +++++
 rtl/ex_redirect_unit.sv | 127 ++++++++++++
 tb/tb_ex_redirect_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_redirect_unit_pkg
// Purpose  : Shared definitions for the EX redirect unit. Holds the branch
//            class encodings carried on ex_op, the redirect FSM state codes
//            and the datapath width constants.
// Revision : 1.0 - initial release
// ============================================================================
package ex_redirect_unit_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   // Branch class encodings on ex_op; codes 11..15 behave as NONE.
   localparam logic [3:0] c_OP_NONE = 4'd0;
   localparam logic [3:0] c_OP_BEQ  = 4'd1;
   localparam logic [3:0] c_OP_BNE  = 4'd2;
   localparam logic [3:0] c_OP_BLEZ = 4'd3;
   localparam logic [3:0] c_OP_BGTZ = 4'd4;
   localparam logic [3:0] c_OP_BLTZ = 4'd5;
   localparam logic [3:0] c_OP_BGEZ = 4'd6;
   localparam logic [3:0] c_OP_J    = 4'd7;
   localparam logic [3:0] c_OP_JAL  = 4'd8;
   localparam logic [3:0] c_OP_JR   = 4'd9;
   localparam logic [3:0] c_OP_JALR = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ex_redirect_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_redirect_unit_if
// Purpose  : EX-stage branch/hazard inputs and the IF redirect/stall outputs.
//            master : the redirect unit (consumes EX/ID info, drives redirect)
//            slave  : the pipeline side (drives EX/ID info, takes redirect)
// Revision : 1.0 - initial release
// ============================================================================
interface ex_redirect_unit_if;
   import ex_redirect_unit_pkg::*;

   logic                 ex_valid;
   logic [3:0]           ex_op;
   logic [XLEN-1:0]      ex_pc;
   logic [XLEN-1:0]      ex_rs_val;
   logic [XLEN-1:0]      ex_rt_val;
   logic [15:0]          ex_imm16;
   logic [25:0]          ex_target26;
   logic                 ex_is_load;
   logic [REG_IDX_W-1:0] ex_rd;
   logic [REG_IDX_W-1:0] id_rs;
   logic [REG_IDX_W-1:0] id_rt;
   logic                 mdu_busy;
   logic                 do_jump;
   logic [XLEN-1:0]      jump_addr;
   logic                 stall;
   logic                 flush;
   logic                 addr_err;
   logic [XLEN-1:0]      redirect_cnt;

   modport master (
      input  ex_valid, ex_op, ex_pc, ex_rs_val, ex_rt_val, ex_imm16,
             ex_target26, ex_is_load, ex_rd, id_rs, id_rt, mdu_busy,
      output do_jump, jump_addr, stall, flush, addr_err, redirect_cnt
   );

   modport slave (
      output ex_valid, ex_op, ex_pc, ex_rs_val, ex_rt_val, ex_imm16,
             ex_target26, ex_is_load, ex_rd, id_rs, id_rt, mdu_busy,
      input  do_jump, jump_addr, stall, flush, addr_err, redirect_cnt
   );

endinterface
`default_nettype wire

// File: rtl/ex_redirect_unit_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Purpose  : Combinational branch/jump resolution for the EX stage.
// Ports    : i_op, i_pc, i_rs_val, i_rt_val, i_imm16, i_target26 -> EX operands
//            o_taken  : branch/jump is taken
//            o_target : redirect target (not checked for alignment here)
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve
   import ex_redirect_unit_pkg::*;
(
   input  logic [3:0]      i_op,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_rs_val,
   input  logic [XLEN-1:0] i_rt_val,
   input  logic [15:0]     i_imm16,
   input  logic [25:0]     i_target26,
   output logic            o_taken,
   output logic [XLEN-1:0] o_target
);

   logic [XLEN-1:0] w_pc4;
   logic [XLEN-1:0] w_br_target;
   logic [XLEN-1:0] w_j_target;

   assign w_pc4       = i_pc + 32'd4;
   // Sign-extended word offset; wraps modulo 2^32.
   assign w_br_target = w_pc4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
   assign w_j_target  = {w_pc4[31:28], i_target26, 2'b00};

   always_comb begin
      o_taken  = 1'b0;
      o_target = w_br_target;
      case (i_op)
         c_OP_BEQ:  o_taken = (i_rs_val == i_rt_val);
         c_OP_BNE:  o_taken = (i_rs_val != i_rt_val);
         c_OP_BLEZ: o_taken = ($signed(i_rs_val) <= 32'sd0);
         c_OP_BGTZ: o_taken = ($signed(i_rs_val) >  32'sd0);
         c_OP_BLTZ: o_taken = ($signed(i_rs_val) <  32'sd0);
         c_OP_BGEZ: o_taken = ($signed(i_rs_val) >= 32'sd0);
         c_OP_J, c_OP_JAL: begin
            o_taken  = 1'b1;
            o_target = w_j_target;
         end
         c_OP_JR, c_OP_JALR: begin
            o_taken  = 1'b1;
            o_target = i_rs_val;
         end
         default: o_taken = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ex_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_redirect_unit
// Purpose  : Resolves EX branches/jumps, issues a one-cycle registered
//            redirect to IF, holds flush for FLUSH_DEPTH cycles per redirect
//            and generates the load-use / MDU stall.
// Ports    : sys_clk, rst (sync, active high)
//            bus (master) : EX/ID inputs, do_jump/jump_addr/stall/flush/
//                           addr_err/redirect_cnt outputs
// Params   : FLUSH_DEPTH (1..7) flush cycles including the redirect cycle
// Revision : 1.0 - initial release
// ============================================================================
module ex_redirect_unit
   import ex_redirect_unit_pkg::*;
#(
   parameter int FLUSH_DEPTH = 2
)(
   input  logic               sys_clk,
   input  logic               rst,
   ex_redirect_unit_if.master bus
);

   // FLUSH holds for the cycles remaining after the REDIRECT cycle.
   localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2:0]      r_flush_cnt;
   logic [2:0]      w_flush_cnt_nxt;
   logic            w_taken;
   logic [XLEN-1:0] w_target;
   logic            w_fire;
   logic            w_redirect;
   logic            w_misalign;
   logic            w_load_use;
   logic            w_flush;
   logic            r_do_jump;
   logic            r_addr_err;
   logic [XLEN-1:0] r_jump_addr;
   logic [XLEN-1:0] r_redirect_cnt;

   branch_resolve u_resolve (
      .i_op       (bus.ex_op),
      .i_pc       (bus.ex_pc),
      .i_rs_val   (bus.ex_rs_val),
      .i_rt_val   (bus.ex_rt_val),
      .i_imm16    (bus.ex_imm16),
      .i_target26 (bus.ex_target26),
      .o_taken    (w_taken),
      .o_target   (w_target)
   );

   // EX contents are wrong-path outside IDLE, so only IDLE may fire.
   assign w_fire     = bus.ex_valid & ~bus.mdu_busy & (r_state == ST_IDLE);
   assign w_redirect = w_fire & w_taken & (w_target[1:0] == 2'b00);
   assign w_misalign = w_fire & w_taken & (w_target[1:0] != 2'b00);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_flush_cnt <= 3'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_redirect) w_state_nxt = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            if (FLUSH_DEPTH > 1) begin
               w_state_nxt     = ST_FLUSH;
               w_flush_cnt_nxt = c_FLUSH_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (r_flush_cnt <= 3'd1) begin
               w_state_nxt     = ST_IDLE;
               w_flush_cnt_nxt = 3'd0;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt - 3'd1;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_flush_cnt_nxt = 3'd0;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_do_jump      <= 1'b0;
         r_addr_err     <= 1'b0;
         r_jump_addr    <= '0;
         r_redirect_cnt <= '0;
      end else begin
         r_do_jump  <= w_redirect;
         r_addr_err <= w_misalign;
         if (w_redirect) begin
            r_jump_addr    <= w_target;
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
         end
      end
   end

   assign w_flush    = (r_state != ST_IDLE);
   assign w_load_use = bus.ex_valid & bus.ex_is_load & (bus.ex_rd != '0) &
                       ((bus.ex_rd == bus.id_rs) | (bus.ex_rd == bus.id_rt));

   // The stalled instruction is discarded during a flush, so flush wins.
   assign bus.stall        = (w_load_use | bus.mdu_busy) & ~w_flush;
   assign bus.flush        = w_flush;
   assign bus.do_jump      = r_do_jump;
   assign bus.jump_addr    = r_jump_addr;
   assign bus.addr_err     = r_addr_err;
   assign bus.redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_redirect_unit
// Purpose  : Directed self-checking bench for ex_redirect_unit. Two instances:
//            dut (FLUSH_DEPTH=2) and dut4 (FLUSH_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_redirect_unit;
   import ex_redirect_unit_pkg::*;

   logic sys_clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   ex_redirect_unit_if bus1 ();
   ex_redirect_unit_if bus2 ();

   ex_redirect_unit #(.FLUSH_DEPTH(2)) dut  (.sys_clk(sys_clk), .rst(rst), .bus(bus1));
   ex_redirect_unit #(.FLUSH_DEPTH(4)) dut4 (.sys_clk(sys_clk), .rst(rst), .bus(bus2));

   always #5 sys_clk = ~sys_clk;

   task automatic step;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_inputs;
      bus1.ex_valid = 0; bus1.ex_op = c_OP_NONE; bus1.ex_pc = '0;
      bus1.ex_rs_val = '0; bus1.ex_rt_val = '0; bus1.ex_imm16 = '0;
      bus1.ex_target26 = '0; bus1.ex_is_load = 0; bus1.ex_rd = '0;
      bus1.id_rs = '0; bus1.id_rt = '0; bus1.mdu_busy = 0;
      bus2.ex_valid = 0; bus2.ex_op = c_OP_NONE; bus2.ex_pc = '0;
      bus2.ex_rs_val = '0; bus2.ex_rt_val = '0; bus2.ex_imm16 = '0;
      bus2.ex_target26 = '0; bus2.ex_is_load = 0; bus2.ex_rd = '0;
      bus2.id_rs = '0; bus2.id_rt = '0; bus2.mdu_busy = 0;
   endtask

   task automatic set_br1(input logic [3:0] op, input logic [31:0] pc,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] imm, input logic [25:0] t26);
      bus1.ex_valid = 1; bus1.ex_op = op; bus1.ex_pc = pc;
      bus1.ex_rs_val = rs; bus1.ex_rt_val = rt;
      bus1.ex_imm16 = imm; bus1.ex_target26 = t26;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst = 1;
      bus1.mdu_busy = 1;
      step(); step();
      n_tests++; if (bus1.do_jump !== 1'b0) begin n_fail++; $display("FAIL rst_do_jump: got %b want 0", bus1.do_jump); end
      n_tests++; if (bus1.jump_addr !== 32'h0) begin n_fail++; $display("FAIL rst_jump_addr: got %h want 0", bus1.jump_addr); end
      n_tests++; if (bus1.flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", bus1.flush); end
      n_tests++; if (bus1.addr_err !== 1'b0) begin n_fail++; $display("FAIL rst_addr_err: got %b want 0", bus1.addr_err); end
      n_tests++; if (bus1.redirect_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", bus1.redirect_cnt); end
      n_tests++; if (bus1.stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall_mdu: got %b want 1", bus1.stall); end
      bus1.mdu_busy = 0;
      #1;
      n_tests++; if (bus1.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_idle: got %b want 0", bus1.stall); end
      rst = 0;
      step();
   endtask

   task automatic test_beq;
      set_br1(c_OP_BEQ, 32'h100, 32'd5, 32'd5, 16'h0004, 26'h0);
      step();
      bus1.ex_valid = 0;
      n_tests++; if (bus1.do_jump !== 1'b1) begin n_fail++; $display("FAIL beq_do_jump: got %b want 1", bus1.do_jump); end
      n_tests++; if (bus1.jump_addr !== 32'h114) begin n_fail++; $display("FAIL beq_addr: got %h want 114", bus1.jump_addr); end
      n_tests++; if (bus1.flush !== 1'b1) begin n_fail++; $display("FAIL beq_flush1: got %b want 1", bus1.flush); end
      n_tests++; if (bus1.redirect_cnt !== 32'd1) begin n_fail++; $display("FAIL beq_cnt: got %h want 1", bus1.redirect_cnt); end
      step();
      n_tests++; if (bus1.do_jump !== 1'b0) begin n_fail++; $display("FAIL beq_pulse: got %b want 0", bus1.do_jump); end
      n_tests++; if (bus1.flush !== 1'b1) begin n_fail++; $display("FAIL beq_flush2: got %b want 1", bus1.flush); end
      step();
      n_tests++; if (bus1.flush !== 1'b0) begin n_fail++; $display("FAIL beq_flush_end: got %b want 0", bus1.flush); end
      n_tests++; if (bus1.jump_addr !== 32'h114) begin n_fail++; $display("FAIL beq_hold: got %h want 114", bus1.jump_addr); end
   endtask

   task automatic test_bne_bltz;
      set_br1(c_OP_BNE, 32'h180, 32'd7, 32'd7, 16'h0008, 26'h0);
      step();
      n_tests++; if (bus1.do_jump !== 1'b0) begin n_fail++; $display("FAIL bne_do_jump: got %b want 0", bus1.do_jump); end
      n_tests++; if (bus1.flush !== 1'b0) begin n_fail++; $display("FAIL bne_flush: got %b want 0", bus1.flush); end
      set_br1(c_OP_BLTZ, 32'h200, 32'h8000_0000, 32'd0, 16'hFFFF, 26'h0);
      step();
      bus1.ex_valid = 0;
      n_tests++; if (bus1.do_jump !== 1'b1) begin n_fail++; $display("FAIL bltz_do_jump: got %b want 1", bus1.do_jump); end
      n_tests++; if (bus1.jump_addr !== 32'h200) begin n_fail++; $display("FAIL bltz_addr: got %h want 200", bus1.jump_addr); end
      n_tests++; if (bus1.redirect_cnt !== 32'd2) begin n_fail++; $display("FAIL bltz_cnt: got %h want 2", bus1.redirect_cnt); end
      step(); step();
   endtask

   task automatic test_addr_err;
      set_br1(c_OP_JR, 32'h300, 32'h0040_0002, 32'd0, 16'h0, 26'h0);
      step();
      bus1.ex_valid = 0;
      n_tests++; if (bus1.addr_err !== 1'b1) begin n_fail++; $display("FAIL jr_addr_err: got %b want 1", bus1.addr_err); end
      n_tests++; if (bus1.do_jump !== 1'b0) begin n_fail++; $display("FAIL jr_do_jump: got %b want 0", bus1.do_jump); end
      n_tests++; if (bus1.jump_addr !== 32'h200) begin n_fail++; $display("FAIL jr_addr_hold: got %h want 200", bus1.jump_addr); end
      n_tests++; if (bus1.redirect_cnt !== 32'd2) begin n_fail++; $display("FAIL jr_cnt: got %h want 2", bus1.redirect_cnt); end
      n_tests++; if (bus1.flush !== 1'b0) begin n_fail++; $display("FAIL jr_flush: got %b want 0", bus1.flush); end
      step();
      n_tests++; if (bus1.addr_err !== 1'b0) begin n_fail++; $display("FAIL jr_err_pulse: got %b want 0", bus1.addr_err); end
   endtask

   task automatic test_flush_ignore;
      set_br1(c_OP_BGEZ, 32'h1000, 32'd0, 32'd0, 16'h0010, 26'h0);
      step();
      n_tests++; if (bus1.jump_addr !== 32'h1044) begin n_fail++; $display("FAIL bgez_addr: got %h want 1044", bus1.jump_addr); end
      set_br1(c_OP_J, 32'h3000_0010, 32'd0, 32'd0, 16'h0, 26'h0000040);
      step();
      n_tests++; if (bus1.jump_addr !== 32'h1044) begin n_fail++; $display("FAIL j_ignored_addr: got %h want 1044", bus1.jump_addr); end
      n_tests++; if (bus1.do_jump !== 1'b0) begin n_fail++; $display("FAIL j_ignored_pulse: got %b want 0", bus1.do_jump); end
      step();
      n_tests++; if (bus1.flush !== 1'b0) begin n_fail++; $display("FAIL j_idle_flush: got %b want 0", bus1.flush); end
      n_tests++; if (bus1.redirect_cnt !== 32'd3) begin n_fail++; $display("FAIL j_ignored_cnt: got %h want 3", bus1.redirect_cnt); end
      step();
      bus1.ex_valid = 0;
      n_tests++; if (bus1.do_jump !== 1'b1) begin n_fail++; $display("FAIL j_do_jump: got %b want 1", bus1.do_jump); end
      n_tests++; if (bus1.jump_addr !== 32'h3000_0100) begin n_fail++; $display("FAIL j_addr: got %h want 30000100", bus1.jump_addr); end
      n_tests++; if (bus1.redirect_cnt !== 32'd4) begin n_fail++; $display("FAIL j_cnt: got %h want 4", bus1.redirect_cnt); end
      step(); step();
   endtask

   task automatic test_load_use;
      bus1.ex_valid = 1; bus1.ex_op = c_OP_NONE; bus1.ex_is_load = 1;
      bus1.ex_rd = 5'd8; bus1.id_rt = 5'd8; bus1.id_rs = 5'd3;
      #1;
      n_tests++; if (bus1.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", bus1.stall); end
      bus1.ex_rd = 5'd0; bus1.id_rt = 5'd0;
      #1;
      n_tests++; if (bus1.stall !== 1'b0) begin n_fail++; $display("FAIL lu_r0: got %b want 0", bus1.stall); end
      bus1.ex_rd = 5'd8; bus1.id_rt = 5'd8;
      set_br1(c_OP_BEQ, 32'h400, 32'd1, 32'd1, 16'h0000, 26'h0);
      #1;
      n_tests++; if (bus1.stall !== 1'b1) begin n_fail++; $display("FAIL lu_br_stall: got %b want 1", bus1.stall); end
      step();
      n_tests++; if (bus1.flush !== 1'b1) begin n_fail++; $display("FAIL lu_flush: got %b want 1", bus1.flush); end
      n_tests++; if (bus1.stall !== 1'b0) begin n_fail++; $display("FAIL lu_flush_stall: got %b want 0", bus1.stall); end
      n_tests++; if (bus1.jump_addr !== 32'h404) begin n_fail++; $display("FAIL lu_addr: got %h want 404", bus1.jump_addr); end
      step();
      n_tests++; if (bus1.stall !== 1'b0) begin n_fail++; $display("FAIL lu_flush2_stall: got %b want 0", bus1.stall); end
      bus1.ex_valid = 0; bus1.ex_is_load = 0;
      step();
      n_tests++; if (bus1.redirect_cnt !== 32'd5) begin n_fail++; $display("FAIL lu_cnt: got %h want 5", bus1.redirect_cnt); end
   endtask

   task automatic test_mdu_hold;
      set_br1(c_OP_BEQ, 32'h500, 32'd9, 32'd9, 16'h0001, 26'h0);
      bus1.mdu_busy = 1;
      step();
      n_tests++; if (bus1.do_jump !== 1'b0) begin n_fail++; $display("FAIL mdu_blocked: got %b want 0", bus1.do_jump); end
      n_tests++; if (bus1.stall !== 1'b1) begin n_fail++; $display("FAIL mdu_stall: got %b want 1", bus1.stall); end
      bus1.mdu_busy = 0;
      step();
      bus1.ex_valid = 0;
      n_tests++; if (bus1.do_jump !== 1'b1) begin n_fail++; $display("FAIL mdu_release: got %b want 1", bus1.do_jump); end
      n_tests++; if (bus1.jump_addr !== 32'h508) begin n_fail++; $display("FAIL mdu_addr: got %h want 508", bus1.jump_addr); end
      n_tests++; if (bus1.redirect_cnt !== 32'd6) begin n_fail++; $display("FAIL mdu_cnt: got %h want 6", bus1.redirect_cnt); end
      step(); step();
   endtask

   task automatic test_reset_mid_flush;
      bus2.ex_valid = 1; bus2.ex_op = c_OP_JAL; bus2.ex_pc = 32'h0;
      bus2.ex_target26 = 26'h10;
      step();
      bus2.ex_valid = 0;
      n_tests++; if (bus2.jump_addr !== 32'h40) begin n_fail++; $display("FAIL d4_jal_addr: got %h want 40", bus2.jump_addr); end
      step();
      n_tests++; if (bus2.flush !== 1'b1) begin n_fail++; $display("FAIL d4_cycle2_flush: got %b want 1", bus2.flush); end
      rst = 1;
      step();
      rst = 0;
      n_tests++; if ({bus2.do_jump, bus2.flush, bus2.addr_err} !== 3'b000) begin n_fail++; $display("FAIL d4_rst_flags: got %b want 000", {bus2.do_jump, bus2.flush, bus2.addr_err}); end
      n_tests++; if (bus2.jump_addr !== 32'h0) begin n_fail++; $display("FAIL d4_rst_addr: got %h want 0", bus2.jump_addr); end
      n_tests++; if (bus2.redirect_cnt !== 32'h0) begin n_fail++; $display("FAIL d4_rst_cnt: got %h want 0", bus2.redirect_cnt); end
      bus2.ex_valid = 1; bus2.ex_op = c_OP_BEQ; bus2.ex_pc = 32'h20;
      bus2.ex_rs_val = 32'd3; bus2.ex_rt_val = 32'd3; bus2.ex_imm16 = 16'h0002;
      step();
      bus2.ex_valid = 0;
      n_tests++; if (bus2.do_jump !== 1'b1) begin n_fail++; $display("FAIL d4_redir: got %b want 1", bus2.do_jump); end
      n_tests++; if (bus2.jump_addr !== 32'h2C) begin n_fail++; $display("FAIL d4_addr: got %h want 2c", bus2.jump_addr); end
      n_tests++; if (bus2.redirect_cnt !== 32'd1) begin n_fail++; $display("FAIL d4_cnt: got %h want 1", bus2.redirect_cnt); end
      for (int i = 2; i <= 4; i++) begin
         step();
         n_tests++; if (bus2.flush !== 1'b1) begin n_fail++; $display("FAIL d4_flush_c%0d: got %b want 1", i, bus2.flush); end
      end
      step();
      n_tests++; if (bus2.flush !== 1'b0) begin n_fail++; $display("FAIL d4_flush_end: got %b want 0", bus2.flush); end
   endtask

   initial begin
      rst = 1;
      test_reset();
      test_beq();
      test_bne_bltz();
      test_addr_err();
      test_flush_ignore();
      test_load_use();
      test_mdu_hold();
      test_reset_mid_flush();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
